// File: rtl/number_spawn_ctrl.sv
// number_spawn_ctrl
//   Spawn controller for a single number mover. Picks lane, direction, speed
//   and digit from a free-running LFSR. Holds the mover in reset between
//   spawns. Retires the number when it leaves the screen or is hit.
//
// Ports
//   clk, resetN      clock, asynchronous active-low reset
//   i_startOfFrame   one-cycle pulse per frame (paces the cooldown)
//   i_enable         allows new spawns (never aborts a live number)
//   i_hit            collision level, only honoured while ACTIVE
//   i_topLeftX       current mover X (pixels, signed)
//   o_moverResetN    active-low mover reset; high only in ARM/ACTIVE
//   o_xSpeed         signed speed, 1/64 pixel per frame
//   o_initialX/Y     mover start position (pixels)
//   o_numberValue    digit 0..9 carried by the number
//   o_active         draw enable, high only in ACTIVE
//   o_hitPulse       one-cycle pulse on a hit
//   o_hitValue       digit captured on the last hit
module number_spawn_ctrl #(
    parameter int          COOLDOWN_FRAMES = 60,
    parameter int          LEFT_LIMIT      = -32,
    parameter int          RIGHT_LIMIT     = 640,
    parameter int          SPEED_BASE      = 30,
    parameter int          LANE_Y_BASE     = 80,
    parameter int          LANE_PITCH      = 96,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               i_startOfFrame,
    input  logic               i_enable,
    input  logic               i_hit,
    input  logic signed [10:0] i_topLeftX,
    output logic               o_moverResetN,
    output logic signed [31:0] o_xSpeed,
    output logic signed [31:0] o_initialX,
    output logic signed [31:0] o_initialY,
    output logic        [3:0]  o_numberValue,
    output logic               o_active,
    output logic               o_hitPulse,
    output logic        [3:0]  o_hitValue
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOLDOWN,
        S_LOAD,
        S_ARM,
        S_ACTIVE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [15:0] r_lfsr;
    logic        r_dir;

    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_spawn;
    logic        w_hit;
    logic        w_exit;

    logic signed [31:0] w_x;
    logic signed [31:0] w_mag;
    logic signed [31:0] w_laneY;
    logic        [3:0]  w_nib;
    logic        [3:0]  w_digit;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11; runs every cycle so the
    // sampled value depends on how long the cooldown actually took.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    // Spawn parameters decoded from the current LFSR value
    assign w_laneY = 32'(LANE_Y_BASE) + 32'(r_lfsr[1:0]) * 32'(LANE_PITCH);
    assign w_mag   = 32'(SPEED_BASE) + 32'(r_lfsr[8:4]);
    assign w_nib   = r_lfsr[12:9];
    assign w_digit = (w_nib >= 4'd10) ? (w_nib - 4'd10) : w_nib;

    // Exit test on the sign-extended mover position
    assign w_x    = {{21{i_topLeftX[10]}}, i_topLeftX};
    assign w_exit = r_dir ? (w_x <= 32'(LEFT_LIMIT)) : (w_x >= 32'(RIGHT_LIMIT));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_load = 1'b0;
        w_cnt_dec  = 1'b0;
        w_spawn    = 1'b0;
        w_hit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) begin
                    w_cnt_load = 1'b1;
                    w_next     = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                // enable=0 freezes both the count and the spawn
                if (i_enable) begin
                    if (r_cnt == 8'd0) begin
                        w_spawn = 1'b1;
                        w_next  = S_LOAD;
                    end else if (i_startOfFrame) begin
                        w_cnt_dec = 1'b1;
                    end
                end
            end
            S_LOAD: w_next = S_ARM;
            S_ARM:  w_next = S_ACTIVE;
            S_ACTIVE: begin
                // hit has priority over leaving the screen
                if (i_hit) begin
                    w_hit      = 1'b1;
                    w_cnt_load = 1'b1;
                    w_next     = S_COOLDOWN;
                end else if (w_exit) begin
                    w_cnt_load = 1'b1;
                    w_next     = S_COOLDOWN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)         r_cnt <= 8'd0;
        else if (w_cnt_load) r_cnt <= 8'(COOLDOWN_FRAMES);
        else if (w_cnt_dec)  r_cnt <= r_cnt - 8'd1;
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state the FSM is in.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            o_moverResetN <= 1'b0;
            o_active      <= 1'b0;
            o_hitPulse    <= 1'b0;
            o_hitValue    <= 4'd0;
            o_numberValue <= 4'd0;
            o_xSpeed      <= 32'(SPEED_BASE);
            o_initialX    <= 32'(LEFT_LIMIT);
            o_initialY    <= 32'(LANE_Y_BASE);
            r_dir         <= 1'b0;
        end else begin
            o_moverResetN <= (w_next == S_ARM) || (w_next == S_ACTIVE);
            o_active      <= (w_next == S_ACTIVE);
            o_hitPulse    <= w_hit;
            if (w_hit) o_hitValue <= o_numberValue;
            if (w_spawn) begin
                r_dir         <= r_lfsr[2];
                o_initialY    <= w_laneY;
                o_numberValue <= w_digit;
                if (r_lfsr[2]) begin
                    o_xSpeed   <= -w_mag;
                    o_initialX <= 32'(RIGHT_LIMIT);
                end else begin
                    o_xSpeed   <= w_mag;
                    o_initialX <= 32'(LEFT_LIMIT);
                end
            end
        end
    end

endmodule
